// File: rtl/neuron_update_scheduler.sv
// neuron_update_scheduler
// Time-multiplexes one shared LIF potential adder across NUM_NEURONS neurons
// once per timestep: INIT, then FETCH/EVAL per neuron, then DONE.
// Holds the membrane potential register file and the per-neuron spike vector.
//
// Ports:
//   CLK, rst_n        clock (rising edge), asynchronous active-low reset
//   start             timestep request, sampled only in IDLE
//   busy, done        busy INIT..DONE, done pulses for one cycle in DONE
//   weight_rd/addr    weight store read strobe and neuron index (FETCH)
//   weight_data       weight returned one cycle after weight_rd
//   set_adder         adder threshold load (INIT)
//   clear_adder       adder spike clear (IDLE and DONE)
//   adder_weight      weight to the adder (follows weight_data in EVAL)
//   adder_potential   stored potential to the adder
//   adder_result/spike combinational adder outputs, consumed at the EVAL edge
//   pot_wr_*          host potential write, accepted only in IDLE
//   spikes            per-neuron spikes of the last timestep
//
// Build option: define SPIKE_COUNT_EN to add the spike_count output.

module neuron_update_scheduler #(
    parameter int unsigned NUM_NEURONS = 30,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   weight_rd,
    output logic [ADDR_W-1:0]      weight_addr,
    input  logic [31:0]            weight_data,
    output logic                   set_adder,
    output logic                   clear_adder,
    output logic [31:0]            adder_weight,
    output logic [31:0]            adder_potential,
    input  logic [31:0]            adder_result,
    input  logic                   adder_spike,
    input  logic                   pot_wr_en,
    input  logic [ADDR_W-1:0]      pot_wr_addr,
    input  logic [31:0]            pot_wr_data,
    output logic [NUM_NEURONS-1:0] spikes
`ifdef SPIKE_COUNT_EN
    ,
    output logic [$clog2(NUM_NEURONS+1)-1:0] spike_count
`endif
);

    localparam int unsigned       WORD_W   = 32;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
`ifdef SPIKE_COUNT_EN
    localparam int unsigned       CNT_W    = $clog2(NUM_NEURONS + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_FETCH = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]   pot_q [NUM_NEURONS];
    logic [WORD_W-1:0]   weight_hold_q;

    logic                busy_d, done_d, weight_rd_d, set_adder_d, clear_adder_d;
    logic [ADDR_W-1:0]   weight_addr_d;
    logic [WORD_W-1:0]   adder_potential_d;
    logic                host_wr;
    logic                in_eval;

    assign in_eval = (state_q == S_EVAL);
    assign host_wr = (state_q == S_IDLE) && pot_wr_en && (32'(pot_wr_addr) < NUM_NEURONS);

    // Weight must reach the adder in the same cycle it arrives; hold it otherwise.
    assign adder_weight = in_eval ? weight_data : weight_hold_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT:  state_d = S_FETCH;
            S_FETCH: state_d = S_EVAL;
            S_EVAL:  state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: decoded from the next state so the registered outputs track the state
    always_comb begin
        busy_d            = (state_d != S_IDLE);
        done_d            = (state_d == S_DONE);
        weight_rd_d       = (state_d == S_FETCH);
        set_adder_d       = (state_d == S_INIT);
        clear_adder_d     = (state_d == S_IDLE) || (state_d == S_DONE);
        idx_d             = idx_q;
        weight_addr_d     = weight_addr;
        adder_potential_d = adder_potential;
        if (state_d == S_INIT) begin
            idx_d = '0;
        end else if (in_eval && (idx_q != LAST_IDX)) begin
            idx_d = idx_q + ADDR_W'(1);
        end
        if (state_d == S_FETCH) begin
            weight_addr_d = idx_d;
        end
        // pot is not written during FETCH, so it can be staged one cycle early
        if (state_d == S_EVAL) begin
            adder_potential_d = pot_q[idx_q];
        end
    end

    // State, output and register-file update
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            weight_rd       <= 1'b0;
            set_adder       <= 1'b0;
            clear_adder     <= 1'b1;
            weight_addr     <= '0;
            adder_potential <= '0;
            weight_hold_q   <= '0;
            spikes          <= '0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i] <= '0;
            end
`ifdef SPIKE_COUNT_EN
            spike_count     <= '0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            busy            <= busy_d;
            done            <= done_d;
            weight_rd       <= weight_rd_d;
            set_adder       <= set_adder_d;
            clear_adder     <= clear_adder_d;
            weight_addr     <= weight_addr_d;
            adder_potential <= adder_potential_d;
            if (host_wr) begin
                pot_q[pot_wr_addr] <= pot_wr_data;
            end
            if (state_q == S_INIT) begin
                spikes <= '0;
`ifdef SPIKE_COUNT_EN
                spike_count <= '0;
`endif
            end
            if (in_eval) begin
                pot_q[idx_q]  <= adder_result;
                spikes[idx_q] <= adder_spike;
                weight_hold_q <= weight_data;
`ifdef SPIKE_COUNT_EN
                if (adder_spike) begin
                    spike_count <= spike_count + CNT_W'(1);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Self-checking bench for neuron_update_scheduler with a behavioural
// integer-valued LIF adder (threshold 40.0, subtract-on-spike) and a
// one-cycle-latency weight store.
module tb_neuron_update_scheduler;

    localparam int unsigned N        = 30;
    localparam int unsigned AW       = 5;
    localparam int          DONE_CYC = int'(2 + 2 * N);
    localparam int          PERIOD   = int'(2 * N + 3);

    localparam logic [31:0] F5   = 32'h40A00000;
    localparam logic [31:0] F10  = 32'h41200000;
    localparam logic [31:0] F15  = 32'h41700000;
    localparam logic [31:0] F20  = 32'h41A00000;
    localparam logic [31:0] F30  = 32'h41F00000;
    localparam logic [31:0] F35  = 32'h420C0000;
    localparam logic [31:0] F40  = 32'h42200000;
    localparam logic [31:0] F100 = 32'h42C80000;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, weight_rd, set_adder, clear_adder;
    logic [AW-1:0] weight_addr;
    logic [31:0]   weight_data = 32'h0;
    logic [31:0]   adder_weight, adder_potential, adder_result;
    logic          adder_spike;
    logic          pot_wr_en;
    logic [AW-1:0] pot_wr_addr;
    logic [31:0]   pot_wr_data;
    logic [N-1:0]  spikes;
`ifdef SPIKE_COUNT_EN
    logic [$clog2(N+1)-1:0] spike_count;
`endif

    logic [31:0] wmem [N];
    int          cyc = 0;
    int          checks, errors;

    int t_init_cyc, t_done_c, t_done_cnt, t_rd_cnt, t_addr_bad, t_ctl_bad, t_busy_bad;
    bit t_timeout;

    neuron_update_scheduler #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
        .CLK             (CLK),
        .rst_n           (rst_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .weight_rd       (weight_rd),
        .weight_addr     (weight_addr),
        .weight_data     (weight_data),
        .set_adder       (set_adder),
        .clear_adder     (clear_adder),
        .adder_weight    (adder_weight),
        .adder_potential (adder_potential),
        .adder_result    (adder_result),
        .adder_spike     (adder_spike),
        .pot_wr_en       (pot_wr_en),
        .pot_wr_addr     (pot_wr_addr),
        .pot_wr_data     (pot_wr_data),
        .spikes          (spikes)
`ifdef SPIKE_COUNT_EN
        ,
        .spike_count     (spike_count)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Weight store: data appears the cycle after the read strobe, junk otherwise
    always @(posedge CLK) weight_data <= (weight_rd === 1'b1) ? wmem[weight_addr] : 32'hDEADBEEF;

    // Non-negative integer <-> IEEE-754 single (all bench values are small integers)
    function automatic int f2i(input logic [31:0] b);
        int          e;
        logic [31:0] m;
        if (b[30:0] == 31'd0) return 0;
        e = int'(b[30:23]) - 127;
        if (e < 0 || e > 23) return 100000;
        m = {8'd0, 1'b1, b[22:0]};
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [31:0] i2f(input int v);
        int          e;
        logic [31:0] m;
        if (v <= 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 24; i++) if ((v >> i) != 0) e = i;
        m = 32'(v) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    // LIF adder: accumulate, spike when strictly above 40.0, subtract threshold
    int sum_c;
    always_comb begin
        sum_c        = f2i(adder_potential) + f2i(adder_weight);
        adder_spike  = (sum_c > 40);
        adder_result = i2f(adder_spike ? sum_c - 40 : sum_c);
    end

    // Starts a timestep and observes it until DONE; returns at the DONE negedge.
    // At observed cycle inj_cycle, start and a pot write are pulsed for one cycle.
    task automatic run_timestep(input int inj_cycle);
        int w;
        t_done_c = -1; t_done_cnt = 0; t_rd_cnt = 0;
        t_addr_bad = 0; t_ctl_bad = 0; t_busy_bad = 0; t_timeout = 0;
        start = 1'b1;
        @(negedge CLK);
        w = 1;
        while (busy !== 1'b1 && w < 5) begin
            @(negedge CLK);
            w++;
        end
        start = 1'b0;
        pot_wr_en = 1'b0;
        t_init_cyc = cyc;
        if (busy !== 1'b1) begin
            t_timeout = 1;
            return;
        end
        for (int r = 1; r <= 100; r++) begin
            if (weight_rd === 1'b1) begin
                if (weight_addr !== AW'(t_rd_cnt) || r != 2 + 2 * t_rd_cnt) t_addr_bad++;
                t_rd_cnt++;
            end
            if ((set_adder === 1'b1) != (r == 1)) t_ctl_bad++;
            if ((clear_adder === 1'b1) != (r == DONE_CYC)) t_ctl_bad++;
            if ((busy === 1'b1) != (r <= DONE_CYC)) t_busy_bad++;
            if (done === 1'b1) begin
                t_done_cnt++;
                t_done_c = r;
                return;
            end
            if (r == inj_cycle) begin
                start = 1'b1; pot_wr_en = 1'b1; pot_wr_addr = '0; pot_wr_data = F100;
            end else if (r == inj_cycle + 1) begin
                start = 1'b0; pot_wr_en = 1'b0;
            end
            @(negedge CLK);
        end
        t_timeout = 1;
    endtask

    task automatic test_reset();
        int nz;
        rst_n = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({busy, done, weight_rd, set_adder, clear_adder} !== 5'b00001) begin
            errors++; $display("FAIL reset_ctl: got %b expected 00001", {busy, done, weight_rd, set_adder, clear_adder});
        end
        checks++;
        if (weight_addr !== '0 || adder_weight !== 32'h0 || adder_potential !== 32'h0) begin
            errors++; $display("FAIL reset_bus: addr %h weight %h pot %h expected all 0", weight_addr, adder_weight, adder_potential);
        end
        checks++;
        if (spikes !== '0) begin
            errors++; $display("FAIL reset_spikes: got %h expected 0", spikes);
        end
        nz = 0;
        for (int i = 0; i < int'(N); i++) if (dut.pot_q[i] !== 32'h0) nz++;
        checks++;
        if (nz != 0) begin
            errors++; $display("FAIL reset_pot: %0d nonzero potentials expected 0", nz);
        end
        rst_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        run_timestep(-10);
        checks++;
        if (t_timeout || t_done_c != DONE_CYC) begin
            errors++; $display("FAIL basic_done_cycle: got %0d (timeout %0d) expected %0d", t_done_c, t_timeout, DONE_CYC);
        end
        checks++;
        if (t_rd_cnt != int'(N) || t_addr_bad != 0) begin
            errors++; $display("FAIL basic_weight_rd: reads %0d bad %0d expected %0d reads 0 bad", t_rd_cnt, t_addr_bad, N);
        end
        checks++;
        if (t_ctl_bad != 0) begin
            errors++; $display("FAIL basic_set_clear: %0d bad cycles expected 0", t_ctl_bad);
        end
        checks++;
        if (t_busy_bad != 0) begin
            errors++; $display("FAIL basic_busy: %0d bad cycles expected 0", t_busy_bad);
        end
        checks++;
        if (spikes !== '0) begin
            errors++; $display("FAIL basic_spikes: got %h expected 0", spikes);
        end
        for (int i = 0; i < int'(N); i++) begin
            checks++;
            if (dut.pot_q[i] !== F10) begin
                errors++; $display("FAIL basic_pot[%0d]: got %h expected %h", i, dut.pot_q[i], F10);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_host_write();
        int bad;
        pot_wr_en = 1'b1; pot_wr_addr = AW'(3); pot_wr_data = F35;
        @(negedge CLK);
        pot_wr_addr = AW'(30); pot_wr_data = 32'h7F7F7F7F;
        @(negedge CLK);
        pot_wr_addr = AW'(7); pot_wr_data = F30;
        run_timestep(-10);
        checks++;
        if (t_timeout || t_done_c != DONE_CYC) begin
            errors++; $display("FAIL host_done: got %0d expected %0d", t_done_c, DONE_CYC);
        end
        checks++;
        if (spikes !== N'(32'h8)) begin
            errors++; $display("FAIL host_spikes: got %h expected %h", spikes, N'(32'h8));
        end
        checks++;
        if (dut.pot_q[3] !== F5) begin
            errors++; $display("FAIL host_pot3: got %h expected %h", dut.pot_q[3], F5);
        end
        checks++;
        if (dut.pot_q[7] !== F40) begin
            errors++; $display("FAIL host_pot7_same_cycle: got %h expected %h", dut.pot_q[7], F40);
        end
        bad = 0;
        for (int i = 0; i < int'(N); i++) if (i != 3 && i != 7 && dut.pot_q[i] !== F20) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL host_pot_others: %0d wrong expected 0", bad);
        end
`ifdef SPIKE_COUNT_EN
        checks++;
        if (spike_count !== 5'd1) begin
            errors++; $display("FAIL host_spike_count: got %0d expected 1", spike_count);
        end
`endif
        @(negedge CLK);
    endtask

    task automatic test_busy_ignore();
        int extra;
        run_timestep(10);
        checks++;
        if (t_timeout || t_done_c != DONE_CYC || t_done_cnt != 1) begin
            errors++; $display("FAIL ignore_done: cycle %0d count %0d expected %0d / 1", t_done_c, t_done_cnt, DONE_CYC);
        end
        checks++;
        if (dut.pot_q[0] !== F30) begin
            errors++; $display("FAIL ignore_pot0: got %h expected %h", dut.pot_q[0], F30);
        end
        checks++;
        if (dut.pot_q[3] !== F15 || dut.pot_q[7] !== F10) begin
            errors++; $display("FAIL ignore_pot3_7: got %h %h expected %h %h", dut.pot_q[3], dut.pot_q[7], F15, F10);
        end
        checks++;
        if (spikes !== N'(32'h80)) begin
            errors++; $display("FAIL ignore_spikes: got %h expected %h", spikes, N'(32'h80));
        end
        checks++;
        if (t_addr_bad != 0 || t_rd_cnt != int'(N)) begin
            errors++; $display("FAIL ignore_weight_rd: reads %0d bad %0d", t_rd_cnt, t_addr_bad);
        end
        extra = 0;
        repeat (6) begin
            @(negedge CLK);
            if (busy === 1'b1 || done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL ignore_queued_start: %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]  exp_pot [5];
        logic [N-1:0] exp_s;
        int           prev;
        exp_pot = '{F10, F20, F30, F40, F10};
        rst_n = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);
        prev = 0;
        for (int t = 0; t < 5; t++) begin
            run_timestep(-10);
            exp_s = (t == 4) ? {N{1'b1}} : '0;
            checks++;
            if (t_timeout || t_done_c != DONE_CYC) begin
                errors++; $display("FAIL b2b_done[%0d]: got %0d expected %0d", t, t_done_c, DONE_CYC);
            end
            checks++;
            if (dut.pot_q[0] !== exp_pot[t] || dut.pot_q[N-1] !== exp_pot[t]) begin
                errors++; $display("FAIL b2b_pot[%0d]: got %h %h expected %h", t, dut.pot_q[0], dut.pot_q[N-1], exp_pot[t]);
            end
            checks++;
            if (spikes !== exp_s) begin
                errors++; $display("FAIL b2b_spikes[%0d]: got %h expected %h", t, spikes, exp_s);
            end
            if (t > 0) begin
                checks++;
                if (t_init_cyc - prev != PERIOD) begin
                    errors++; $display("FAIL b2b_period[%0d]: got %0d expected %0d", t, t_init_cyc - prev, PERIOD);
                end
            end
            prev = t_init_cyc;
        end
`ifdef SPIKE_COUNT_EN
        checks++;
        if (spike_count !== 5'd30) begin
            errors++; $display("FAIL b2b_spike_count: got %0d expected 30", spike_count);
        end
`endif
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int nz, act;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (19) @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || weight_addr !== AW'(9)) begin
            errors++; $display("FAIL mid_pre_reset: busy %b addr %0d expected 1 / 9", busy, weight_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, weight_rd, set_adder, clear_adder} !== 5'b00001) begin
            errors++; $display("FAIL mid_reset_ctl: got %b expected 00001", {busy, done, weight_rd, set_adder, clear_adder});
        end
        checks++;
        if (weight_addr !== '0 || adder_weight !== 32'h0 || adder_potential !== 32'h0 || spikes !== '0) begin
            errors++; $display("FAIL mid_reset_bus: addr %h w %h p %h spk %h expected 0", weight_addr, adder_weight, adder_potential, spikes);
        end
        nz = 0;
        for (int i = 0; i < int'(N); i++) if (dut.pot_q[i] !== 32'h0) nz++;
        checks++;
        if (nz != 0) begin
            errors++; $display("FAIL mid_reset_pot: %0d nonzero expected 0", nz);
        end
        act = 0;
        for (int i = 0; i < 80; i++) begin
            if (i == 2) rst_n = 1'b1;
            @(negedge CLK);
            if (done === 1'b1 || busy === 1'b1) act++;
        end
        checks++;
        if (act != 0) begin
            errors++; $display("FAIL mid_no_done: %0d active cycles expected 0", act);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        pot_wr_en = 1'b0;
        pot_wr_addr = '0;
        pot_wr_data = 32'h0;
        for (int i = 0; i < int'(N); i++) wmem[i] = F10;
        test_reset();
        test_basic();
        test_host_write();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
